// File: rtl/rr_merge.sv
// rr_merge: N-master to 1-slave native-bus merge with round-robin arbitration.
// The grant is held for a whole transaction (valid..ready), so requests never
// interleave. Each transaction pays one arbitration cycle in IDLE.
// Slot layouts: request {valid, addr, wdata, wstrb}, response {rdata, ready}.
module rr_merge #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  localparam int unsigned REQ_W    = 1 + ADDR_W + DATA_W + DATA_W / 8,
  localparam int unsigned RESP_W   = DATA_W + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS*REQ_W-1:0]    m_req,
  output logic [N_MASTERS*RESP_W-1:0]   m_resp,
  output logic [REQ_W-1:0]              s_req,
  input  logic [RESP_W-1:0]             s_resp,
  output logic [N_MASTERS-1:0]          grant
);

  localparam int unsigned PW = $clog2(N_MASTERS);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gnt_idx_q, gnt_idx_d;

  logic [N_MASTERS-1:0] valid_vec;
  logic                 any_valid;
  logic [PW-1:0]        winner;
  logic [REQ_W-1:0]     gnt_req;
  logic                 gnt_valid;
  logic                 s_ready;
  logic [PW-1:0]        gnt_idx_inc;

  assign s_ready   = s_resp[0];
  assign gnt_valid = gnt_req[REQ_W-1];

  // Explicit wrap so a non-power-of-2 count goes N-1 -> 0, never N.
  assign gnt_idx_inc = (gnt_idx_q == PW'(N_MASTERS - 1)) ? '0 : gnt_idx_q + 1'b1;

  // Gather per-master valid bits and select the granted master's request.
  always_comb begin
    valid_vec = '0;
    gnt_req   = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      valid_vec[i] = m_req[i*REQ_W + REQ_W - 1];
      if (PW'(i) == gnt_idx_q) begin
        gnt_req = m_req[i*REQ_W +: REQ_W];
      end
    end
  end

  // Round-robin search: first valid index starting at ptr, wrapping modulo N.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    any_valid = 1'b0;
    winner    = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= N_MASTERS) begin
        cand = cand - N_MASTERS;
      end
      if (!any_valid && valid_vec[cand]) begin
        any_valid = 1'b1;
        winner    = cand[PW-1:0];
      end
    end
  end

  // State, pointer and grant index registers; reset drops any in-flight grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end

  // Next-state logic and bus muxing; ready from the slave beats a dropped valid.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
    s_req     = '0;
    m_resp    = '0;
    grant     = '0;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          gnt_idx_d = winner;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        s_req = gnt_req;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
          if (PW'(i) == gnt_idx_q) begin
            m_resp[i*RESP_W +: RESP_W] = s_resp;
            grant[i]                   = 1'b1;
          end
        end
        if (s_ready) begin
          ptr_d   = gnt_idx_inc;
          state_d = IDLE;
        end else if (!gnt_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rr_merge.sv
// Directed bench for rr_merge: a 2-master instance for most scenarios and a
// 3-master instance for pointer wrap-around.
module tb_rr_merge;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
  localparam int unsigned RESP_W = DATA_W + 1;

  logic clk = 1'b0;
  logic rst;

  logic [2*REQ_W-1:0]  m_req2;
  logic [2*RESP_W-1:0] m_resp2;
  logic [REQ_W-1:0]    s_req2;
  logic [RESP_W-1:0]   s_resp2;
  logic [1:0]          grant2;

  logic [3*REQ_W-1:0]  m_req3;
  logic [3*RESP_W-1:0] m_resp3;
  logic [REQ_W-1:0]    s_req3;
  logic [RESP_W-1:0]   s_resp3;
  logic [2:0]          grant3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_merge #(.N_MASTERS(2), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut2 (
    .clk(clk), .rst(rst), .m_req(m_req2), .m_resp(m_resp2),
    .s_req(s_req2), .s_resp(s_resp2), .grant(grant2)
  );

  rr_merge #(.N_MASTERS(3), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut3 (
    .clk(clk), .rst(rst), .m_req(m_req3), .m_resp(m_resp3),
    .s_req(s_req3), .s_resp(s_resp3), .grant(grant3)
  );

  function automatic logic [REQ_W-1:0] mk(input logic v, input logic [ADDR_W-1:0] a,
                                          input logic [DATA_W-1:0] d, input logic [DATA_W/8-1:0] s);
    return {v, a, d, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [REQ_W-1:0] r0;
    r0 = mk(1'b1, 32'h100, 32'h11, 4'hF);
    rst = 1'b1; m_req2 = '0; s_resp2 = '0; m_req3 = '0; s_resp3 = '0;
    tick();
    checks++; if (s_req2 !== '0) begin errors++; $display("FAIL reset_s_req: got %h expected 0", s_req2); end
    checks++; if (grant2 !== 2'b00) begin errors++; $display("FAIL reset_grant2: got %b expected 00", grant2); end
    checks++; if (m_resp2 !== '0) begin errors++; $display("FAIL reset_m_resp: got %h expected 0", m_resp2); end
    checks++; if (grant3 !== 3'b000) begin errors++; $display("FAIL reset_grant3: got %b expected 000", grant3); end
    rst = 1'b0;
    m_req2[REQ_W-1:0] = r0;
    #1;
    checks++; if (grant2 !== 2'b00) begin errors++; $display("FAIL reset_idle_grant: got %b expected 00", grant2); end
    tick();
    checks++; if (grant2 !== 2'b01) begin errors++; $display("FAIL reset_first_grant: got %b expected 01", grant2); end
    checks++; if (s_req2 !== r0) begin errors++; $display("FAIL reset_pass_through: got %h expected %h", s_req2, r0); end
    // Reset mid-BUSY must clear outputs without waiting for a clock edge.
    rst = 1'b1;
    #1;
    checks++; if (s_req2[REQ_W-1] !== 1'b0) begin errors++; $display("FAIL reset_mid_valid: got %b expected 0", s_req2[REQ_W-1]); end
    checks++; if (grant2 !== 2'b00) begin errors++; $display("FAIL reset_mid_grant: got %b expected 00", grant2); end
    checks++; if (m_resp2 !== '0) begin errors++; $display("FAIL reset_mid_resp: got %h expected 0", m_resp2); end
    #1 rst = 1'b0;
    #1;
    checks++; if (grant2 !== 2'b00) begin errors++; $display("FAIL reset_after_release: got %b expected 00", grant2); end
    tick();
    checks++; if (grant2 !== 2'b01) begin errors++; $display("FAIL reset_regrant: got %b expected 01", grant2); end
    m_req2 = '0;
    tick();
    checks++; if (grant2 !== 2'b00) begin errors++; $display("FAIL reset_abort_idle: got %b expected 00", grant2); end
  endtask

  task automatic test_single();
    logic [REQ_W-1:0]  r1;
    logic [DATA_W-1:0] seen_rdata;
    int r1_cnt;
    int m0_cnt;
    r1 = mk(1'b1, 32'h10, 32'h0, 4'h0);
    r1_cnt = 0; m0_cnt = 0; seen_rdata = '0;
    m_req2[2*REQ_W-1:REQ_W] = r1;
    #1;
    for (int c = 0; c < 4; c++) begin
      tick();
      s_resp2 = (c == 3) ? {32'hCAFE0001, 1'b1} : '0;
      #1;
      checks++; if (grant2 !== 2'b10) begin errors++; $display("FAIL single_grant c%0d: got %b expected 10", c, grant2); end
      checks++; if (s_req2 !== r1) begin errors++; $display("FAIL single_s_req c%0d: got %h expected %h", c, s_req2, r1); end
      if (m_resp2[RESP_W] === 1'b1) begin r1_cnt++; seen_rdata = m_resp2[2*RESP_W-1:RESP_W+1]; end
      if (m_resp2[0] === 1'b1) m0_cnt++;
      if (c < 3) begin
        tick();
        s_resp2 = '0;
        c = c;
      end
      if (c < 3) begin
        // Stay aligned: undo the extra edge consumed above by counting it as a cycle.
        c++;
        s_resp2 = (c == 3) ? {32'hCAFE0001, 1'b1} : '0;
        #1;
        checks++; if (grant2 !== 2'b10) begin errors++; $display("FAIL single_grant c%0d: got %b expected 10", c, grant2); end
        if (m_resp2[RESP_W] === 1'b1) begin r1_cnt++; seen_rdata = m_resp2[2*RESP_W-1:RESP_W+1]; end
        if (m_resp2[0] === 1'b1) m0_cnt++;
      end
    end
    tick();
    s_resp2 = '0;
    m_req2 = '0;
    #1;
    checks++; if (grant2 !== 2'b00) begin errors++; $display("FAIL single_done_idle: got %b expected 00", grant2); end
    checks++; if (r1_cnt !== 1) begin errors++; $display("FAIL single_ready_pulses: got %0d expected 1", r1_cnt); end
    checks++; if (m0_cnt !== 0) begin errors++; $display("FAIL single_m0_ready: got %0d expected 0", m0_cnt); end
    checks++; if (seen_rdata !== 32'hCAFE0001) begin errors++; $display("FAIL single_rdata: got %h expected cafe0001", seen_rdata); end
  endtask

  task automatic test_contention();
    logic [REQ_W-1:0]    ra, rb;
    logic [2*RESP_W-1:0] exp_resp;
    logic [1:0]          exp_grant;
    logic [DATA_W-1:0]   rd;
    ra = mk(1'b1, 32'h200, 32'hA0, 4'hF);
    rb = mk(1'b1, 32'h300, 32'hB0, 4'h3);
    m_req2 = {rb, ra};
    #1;
    checks++; if (s_req2[REQ_W-1] !== 1'b0) begin errors++; $display("FAIL cont_idle_valid: got %b expected 0", s_req2[REQ_W-1]); end
    for (int k = 0; k < 4; k++) begin
      tick();
      rd = 32'h5000 + k;
      s_resp2 = {rd, 1'b1};
      #1;
      exp_grant = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_resp = '0;
      if (k % 2 == 0) exp_resp[RESP_W-1:0] = {rd, 1'b1};
      else            exp_resp[2*RESP_W-1:RESP_W] = {rd, 1'b1};
      checks++; if (grant2 !== exp_grant) begin errors++; $display("FAIL cont_grant k%0d: got %b expected %b", k, grant2, exp_grant); end
      checks++; if (s_req2 !== ((k % 2 == 0) ? ra : rb)) begin errors++; $display("FAIL cont_s_req k%0d: got %h", k, s_req2); end
      checks++; if (m_resp2 !== exp_resp) begin errors++; $display("FAIL cont_resp k%0d: got %h expected %h", k, m_resp2, exp_resp); end
      tick();
      s_resp2 = '0;
      #1;
      checks++; if (grant2 !== 2'b00) begin errors++; $display("FAIL cont_idle_grant k%0d: got %b expected 00", k, grant2); end
      checks++; if (s_req2[REQ_W-1] !== 1'b0) begin errors++; $display("FAIL cont_idle_s_valid k%0d: got %b expected 0", k, s_req2[REQ_W-1]); end
    end
    m_req2 = '0;
  endtask

  task automatic test_abort();
    logic [REQ_W-1:0] r0, r1;
    r0 = mk(1'b1, 32'h400, 32'h40, 4'h1);
    r1 = mk(1'b1, 32'h500, 32'h50, 4'h2);
    // Pointer is 0: m0 granted, then aborts while m1 waits.
    m_req2[REQ_W-1:0] = r0;
    tick();
    checks++; if (grant2 !== 2'b01) begin errors++; $display("FAIL abort_grant_m0: got %b expected 01", grant2); end
    m_req2[2*REQ_W-1:REQ_W] = r1;
    #1;
    checks++; if (m_resp2 !== '0) begin errors++; $display("FAIL abort_pending_resp: got %h expected 0", m_resp2); end
    tick();
    m_req2[REQ_W-1:0] = '0;
    #1;
    checks++; if (s_req2[REQ_W-1] !== 1'b0) begin errors++; $display("FAIL abort_pass_valid: got %b expected 0", s_req2[REQ_W-1]); end
    checks++; if (grant2 !== 2'b01) begin errors++; $display("FAIL abort_still_busy: got %b expected 01", grant2); end
    tick();
    checks++; if (grant2 !== 2'b00) begin errors++; $display("FAIL abort_to_idle: got %b expected 00", grant2); end
    tick();
    checks++; if (grant2 !== 2'b10) begin errors++; $display("FAIL abort_m1_granted: got %b expected 10", grant2); end
    s_resp2 = {32'h1, 1'b1};
    tick();
    s_resp2 = '0; m_req2 = '0;
    // Pointer now 0; m0 completes so pointer becomes 1.
    m_req2[REQ_W-1:0] = r0;
    tick();
    s_resp2 = {32'h2, 1'b1};
    tick();
    s_resp2 = '0;
    m_req2 = '0;
    m_req2[2*REQ_W-1:REQ_W] = r1;
    tick();
    checks++; if (grant2 !== 2'b10) begin errors++; $display("FAIL abort2_grant_m1: got %b expected 10", grant2); end
    m_req2 = '0;
    tick();
    checks++; if (grant2 !== 2'b00) begin errors++; $display("FAIL abort2_idle: got %b expected 00", grant2); end
    // Abort must not advance the pointer: with both valid, m1 (ptr=1) wins.
    m_req2 = {r1, r0};
    tick();
    checks++; if (grant2 !== 2'b10) begin errors++; $display("FAIL abort2_ptr_kept: got %b expected 10", grant2); end
    s_resp2 = {32'h3, 1'b1};
    tick();
    s_resp2 = '0; m_req2 = '0;
    #1;
  endtask

  task automatic test_back_to_back();
    logic [REQ_W-1:0] r0;
    r0 = mk(1'b1, 32'h600, 32'h60, 4'hF);
    m_req2[REQ_W-1:0] = r0;
    for (int k = 0; k < 3; k++) begin
      tick();
      s_resp2 = {32'h7000 + k, 1'b1};
      #1;
      checks++; if (grant2 !== 2'b01) begin errors++; $display("FAIL b2b_grant k%0d: got %b expected 01", k, grant2); end
      checks++; if (m_resp2[0] !== 1'b1) begin errors++; $display("FAIL b2b_ready k%0d: got %b expected 1", k, m_resp2[0]); end
      tick();
      s_resp2 = '0;
      #1;
      checks++; if (grant2 !== 2'b00) begin errors++; $display("FAIL b2b_idle k%0d: got %b expected 00", k, grant2); end
      checks++; if (s_req2[REQ_W-1] !== 1'b0) begin errors++; $display("FAIL b2b_idle_valid k%0d: got %b expected 0", k, s_req2[REQ_W-1]); end
    end
    m_req2 = '0;
  endtask

  task automatic test_wrap();
    logic [REQ_W-1:0] q0, q1, q2;
    q0 = mk(1'b1, 32'h800, 32'h80, 4'h1);
    q1 = mk(1'b1, 32'h900, 32'h90, 4'h2);
    q2 = mk(1'b1, 32'hA00, 32'hA0, 4'h4);
    m_req3[2*REQ_W-1:REQ_W] = q1;
    tick();
    checks++; if (grant3 !== 3'b010) begin errors++; $display("FAIL wrap_m1: got %b expected 010", grant3); end
    s_resp3 = {32'h1, 1'b1};
    tick();
    s_resp3 = '0;
    m_req3 = '0;
    // Pointer is 2: m2 beats m0.
    m_req3[REQ_W-1:0] = q0;
    m_req3[3*REQ_W-1:2*REQ_W] = q2;
    tick();
    checks++; if (grant3 !== 3'b100) begin errors++; $display("FAIL wrap_m2_first: got %b expected 100", grant3); end
    checks++; if (s_req3 !== q2) begin errors++; $display("FAIL wrap_s_req: got %h expected %h", s_req3, q2); end
    s_resp3 = {32'h2, 1'b1};
    #1;
    checks++; if (m_resp3[2*RESP_W] !== 1'b1) begin errors++; $display("FAIL wrap_m2_ready: got %b expected 1", m_resp3[2*RESP_W]); end
    tick();
    s_resp3 = '0;
    m_req3[3*REQ_W-1:2*REQ_W] = '0;
    #1;
    checks++; if (grant3 !== 3'b000) begin errors++; $display("FAIL wrap_idle: got %b expected 000", grant3); end
    tick();
    checks++; if (grant3 !== 3'b001) begin errors++; $display("FAIL wrap_m0_next: got %b expected 001", grant3); end
    s_resp3 = {32'h3, 1'b1};
    tick();
    s_resp3 = '0;
    m_req3 = '0;
    #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_abort();
    test_back_to_back();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
